// File: rtl/adc_channel_scheduler.sv
// Shares one RC-slope ADC across NCH channels through an external analog mux.
// Each masked channel is discharged, ramp-counted against the comparator, then stored.
module adc_channel_scheduler #(
  parameter int N         = 8,
  parameter int NCH       = 4,
  parameter int DISCH_CYC = 120,
  parameter int TICK_DIV  = 18,
  localparam int SELW     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [NCH-1:0]    ch_mask,
  input  logic              compared_value,
  output logic [SELW-1:0]   mux_sel,
  output logic              discharge,
  output logic              busy,
  output logic              sample_valid,
  output logic [SELW-1:0]   sample_ch,
  output logic [N-1:0]      sample_data,
  output logic              sample_ovf,
  output logic [NCH*N-1:0]  result,
  output logic              frame_done
);

  localparam int DW = $clog2(DISCH_CYC + 1);
  localparam int TW = $clog2(TICK_DIV + 1);
  localparam logic [N-1:0] FULL = {N{1'b1}};

  typedef enum logic [1:0] {IDLE = 2'd0, DISCH = 2'd1, CONV = 2'd2, STORE = 2'd3} state_t;

  state_t            state_r, state_next_s;
  logic              comp_meta_r, comp_s_r;
  logic [NCH-1:0]    mask_r, mask_next_s;
  logic [SELW-1:0]   mux_sel_r, mux_next_s;
  logic [DW-1:0]     disch_r, disch_next_s;
  logic [TW-1:0]     tick_r, tick_next_s;
  logic [N-1:0]      count_r, count_next_s;
  logic              store_s, ovf_s;
  logic [SELW:0]     first_s, higher_s;
  logic              discharge_r, busy_r, sample_valid_r, sample_ovf_r, frame_done_r;
  logic [SELW-1:0]   sample_ch_r;
  logic [N-1:0]      sample_data_r;
  logic [NCH*N-1:0]  result_r;

  // Lowest set bit of mask at index >= from; MSB of the return flags "found".
  function automatic logic [SELW:0] pick_bit(input logic [NCH-1:0] mask, input int from);
    logic [SELW:0] r;
    r = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (mask[k] && (k >= from)) r = {1'b1, SELW'(k)};
      else r = r;
    end
    return r;
  endfunction

  // Two-flop synchroniser for the asynchronous comparator output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      comp_meta_r <= 1'b0;
      comp_s_r    <= 1'b0;
    end else begin
      comp_meta_r <= compared_value;
      comp_s_r    <= comp_meta_r;
    end
  end

  // Next-state and counter control for the discharge/ramp/store sequence.
  always_comb begin
    state_next_s = state_r;
    mask_next_s  = mask_r;
    mux_next_s   = mux_sel_r;
    disch_next_s = disch_r;
    tick_next_s  = tick_r;
    count_next_s = count_r;
    store_s      = 1'b0;
    ovf_s        = 1'b0;
    first_s      = pick_bit(ch_mask, 0);
    higher_s     = pick_bit(mask_r, int'(mux_sel_r) + 1);
    case (state_r)
      IDLE: begin
        if (enable && first_s[SELW]) begin
          mask_next_s  = ch_mask;
          mux_next_s   = first_s[SELW-1:0];
          disch_next_s = '0;
          state_next_s = DISCH;
        end else begin
          state_next_s = IDLE;
        end
      end
      DISCH: begin
        if (disch_r == DW'(DISCH_CYC - 1)) begin
          state_next_s = CONV;
          count_next_s = '0;
          tick_next_s  = '0;
        end else begin
          disch_next_s = disch_r + DW'(1);
        end
      end
      CONV: begin
        // A comparator trip wins over a coinciding tick, so the count freezes.
        if (comp_s_r) begin
          state_next_s = STORE;
          store_s      = 1'b1;
        end else if (tick_r == TW'(TICK_DIV - 1)) begin
          tick_next_s = '0;
          if (count_r == FULL) begin
            state_next_s = STORE;
            store_s      = 1'b1;
            ovf_s        = 1'b1;
          end else begin
            count_next_s = count_r + N'(1);
          end
        end else begin
          tick_next_s = tick_r + TW'(1);
        end
      end
      STORE: begin
        disch_next_s = '0;
        if (higher_s[SELW]) begin
          mux_next_s   = higher_s[SELW-1:0];
          state_next_s = DISCH;
        end else if (enable && first_s[SELW]) begin
          mask_next_s  = ch_mask;
          mux_next_s   = first_s[SELW-1:0];
          state_next_s = DISCH;
        end else begin
          state_next_s = IDLE;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State, counters and registered outputs; samples are captured on entry to STORE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r        <= IDLE;
      mask_r         <= '0;
      mux_sel_r      <= '0;
      disch_r        <= '0;
      tick_r         <= '0;
      count_r        <= '0;
      discharge_r    <= 1'b1;
      busy_r         <= 1'b0;
      sample_valid_r <= 1'b0;
      sample_ch_r    <= '0;
      sample_data_r  <= '0;
      sample_ovf_r   <= 1'b0;
      result_r       <= '0;
      frame_done_r   <= 1'b0;
    end else begin
      state_r        <= state_next_s;
      mask_r         <= mask_next_s;
      mux_sel_r      <= mux_next_s;
      disch_r        <= disch_next_s;
      tick_r         <= tick_next_s;
      count_r        <= count_next_s;
      discharge_r    <= (state_next_s != CONV);
      busy_r         <= (state_next_s != IDLE);
      sample_valid_r <= store_s;
      frame_done_r   <= store_s && !higher_s[SELW];
      if (store_s) begin
        sample_ch_r                        <= mux_sel_r;
        sample_data_r                      <= count_r;
        sample_ovf_r                       <= ovf_s;
        result_r[int'(mux_sel_r)*N +: N]   <= count_r;
      end else begin
        sample_ch_r <= sample_ch_r;
      end
    end
  end

  assign mux_sel      = mux_sel_r;
  assign discharge    = discharge_r;
  assign busy         = busy_r;
  assign sample_valid = sample_valid_r;
  assign sample_ch    = sample_ch_r;
  assign sample_data  = sample_data_r;
  assign sample_ovf   = sample_ovf_r;
  assign result       = result_r;
  assign frame_done   = frame_done_r;

endmodule
